// File: rtl/traffic_intersection_ctrl.sv
// NS/EW intersection controller: one FSM sequences left/green/yellow/all-red phases with emergency hold.
// Lamps decode combinationally from state (zero latency), emergency takes effect one edge later; no backpressure.
module traffic_intersection_ctrl #(
  parameter int LEFT_CYC   = 5,
  parameter int GREEN_CYC  = 10,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int CNT_W      = 5,
  parameter bit START_EW   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  input  logic       ns_left_req,
  input  logic       ew_left_req,
  output logic [3:0] ns_out,
  output logic [3:0] ew_out,
  output logic       emerg_active,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    NS_LEFT    = 4'd0,
    NS_GREEN   = 4'd1,
    NS_YELLOW  = 4'd2,
    CLR_TO_EW  = 4'd3,
    EW_LEFT    = 4'd4,
    EW_GREEN   = 4'd5,
    EW_YELLOW  = 4'd6,
    CLR_TO_NS  = 4'd7,
    EMERG      = 4'd8,
    RESUME_CLR = 4'd9
  } state_t;

  // Lamp encoding {left, green, yellow, red}
  localparam logic [3:0] LAMP_LEFT   = 4'b1001;
  localparam logic [3:0] LAMP_GREEN  = 4'b0100;
  localparam logic [3:0] LAMP_YELLOW = 4'b0010;
  localparam logic [3:0] LAMP_RED    = 4'b0001;

  localparam logic [CNT_W-1:0] LEFT_LAST   = CNT_W'(LEFT_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam state_t RESET_STATE = START_EW ? CLR_TO_EW : CLR_TO_NS;

  state_t           state, state_nxt;
  state_t           saved, saved_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] last;
  logic             at_last;
  logic             ns_pend, ew_pend;
  logic             ns_enter, ew_enter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RESET_STATE;
      saved   <= NS_LEFT;
      cnt     <= '0;
      ns_pend <= 1'b0;
      ew_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      saved   <= saved_nxt;
      cnt     <= cnt_nxt;
      ns_pend <= ns_enter ? 1'b0 : (ns_pend | ns_left_req);
      ew_pend <= ew_enter ? 1'b0 : (ew_pend | ew_left_req);
    end
  end

  // Clearance and resume states share the all-red duration
  always_comb begin
    case (state)
      NS_LEFT, EW_LEFT:     last = LEFT_LAST;
      NS_GREEN, EW_GREEN:   last = GREEN_LAST;
      NS_YELLOW, EW_YELLOW: last = YELLOW_LAST;
      default:              last = ALLRED_LAST;
    endcase
  end

  assign at_last = (cnt == last);

  always_comb begin
    state_nxt = state;
    saved_nxt = saved;
    cnt_nxt   = cnt + CNT_W'(1);
    if (state == EMERG) begin
      cnt_nxt = cnt;
      if (!emergency) begin
        state_nxt = RESUME_CLR;
        cnt_nxt   = '0;
      end
    end else if (emergency || state > RESUME_CLR) begin
      // Re-entry from RESUME_CLR keeps the originally interrupted phase
      state_nxt = EMERG;
      cnt_nxt   = cnt;
      if (state > RESUME_CLR) begin
        saved_nxt = CLR_TO_NS;
      end else if (state != RESUME_CLR) begin
        saved_nxt = state;
      end
    end else if (at_last) begin
      cnt_nxt = '0;
      case (state)
        NS_LEFT:    state_nxt = NS_GREEN;
        NS_GREEN:   state_nxt = NS_YELLOW;
        NS_YELLOW:  state_nxt = CLR_TO_EW;
        CLR_TO_EW:  state_nxt = ew_pend ? EW_LEFT : EW_GREEN;
        EW_LEFT:    state_nxt = EW_GREEN;
        EW_GREEN:   state_nxt = EW_YELLOW;
        EW_YELLOW:  state_nxt = CLR_TO_NS;
        CLR_TO_NS:  state_nxt = ns_pend ? NS_LEFT : NS_GREEN;
        RESUME_CLR: state_nxt = saved;
        default:    state_nxt = EMERG;
      endcase
    end
  end

  assign ns_enter = (state_nxt == NS_LEFT) && (state != NS_LEFT);
  assign ew_enter = (state_nxt == EW_LEFT) && (state != EW_LEFT);

  always_comb begin
    ns_out = LAMP_RED;
    ew_out = LAMP_RED;
    case (state)
      NS_LEFT:   ns_out = LAMP_LEFT;
      NS_GREEN:  ns_out = LAMP_GREEN;
      NS_YELLOW: ns_out = LAMP_YELLOW;
      EW_LEFT:   ew_out = LAMP_LEFT;
      EW_GREEN:  ew_out = LAMP_GREEN;
      EW_YELLOW: ew_out = LAMP_YELLOW;
      default: ;
    endcase
  end

  assign emerg_active = (state == EMERG) || (state == RESUME_CLR);
  assign phase        = state;

endmodule
